// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 receiver plus 3-byte command frame parser.
// Emits one-cycle control pulses for write/read/stop/soft-reset.
`timescale 1ns/1ps
module uart_cmd_rx #(
  parameter int          CLKS_PER_BIT = 64,
  parameter int          TIMEOUT_CLKS = 65536,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       start_write,
  output logic       start_read,
  output logic       stop_cmd,
  output logic       soft_rst,
  output logic       cmd_err,
  output logic [7:0] last_opcode,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_FIRE  = TW'(TIMEOUT_CLKS - 2);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE, P_OP, P_CHK
  } p_state_t;

  logic rx_meta, rx_s;

  rx_state_t rx_state, rx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] sh, sh_nxt;
  logic brk, brk_nxt;
  logic dv_nxt, ferr_nxt;

  p_state_t p_state, p_nxt;
  logic [7:0] op, op_nxt;
  logic [7:0] lop_nxt;
  logic [TW-1:0] tcnt, t_nxt;
  logic sw_n, sr_n, sp_n, so_n, ce_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // brk blocks a new start after a low stop bit until the line goes high
  always_comb begin
    rx_nxt   = rx_state;
    cnt_nxt  = cnt + 1'b1;
    idx_nxt  = idx;
    sh_nxt   = sh;
    brk_nxt  = brk & ~rx_s;
    dv_nxt   = 1'b0;
    ferr_nxt = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s && !brk) rx_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_MID) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          rx_nxt  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_END) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, sh[7:1]};
          idx_nxt = idx + 1'b1;
          if (idx == 3'd7) rx_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_END) begin
          cnt_nxt  = '0;
          dv_nxt   = rx_s;
          ferr_nxt = ~rx_s;
          brk_nxt  = ~rx_s;
          rx_nxt   = RX_CLEANUP;
        end
      end
      RX_CLEANUP: begin
        cnt_nxt = '0;
        rx_nxt  = RX_IDLE;
      end
      default: begin
        cnt_nxt = '0;
        rx_nxt  = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      brk       <= 1'b0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= '0;
    end else begin
      rx_state  <= rx_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      sh        <= sh_nxt;
      brk       <= brk_nxt;
      rx_dv     <= dv_nxt;
      frame_err <= ferr_nxt;
      if (dv_nxt) rx_byte <= sh;
    end
  end

  // T_FIRE is one short so the registered cmd_err lands
  // TIMEOUT_CLKS clks after the last rx_dv
  always_comb begin
    p_nxt   = p_state;
    op_nxt  = op;
    lop_nxt = last_opcode;
    t_nxt   = tcnt;
    sw_n    = 1'b0;
    sr_n    = 1'b0;
    sp_n    = 1'b0;
    so_n    = 1'b0;
    ce_n    = 1'b0;
    if (p_state != P_IDLE && tcnt != T_MAX)
      t_nxt = tcnt + 1'b1;
    if (rx_dv) t_nxt = '0;
    unique case (p_state)
      P_IDLE: begin
        if (rx_dv && rx_byte == HEADER) p_nxt = P_OP;
      end
      P_OP: begin
        if (rx_dv) begin
          op_nxt = rx_byte;
          p_nxt  = P_CHK;
        end
      end
      P_CHK: begin
        if (rx_dv) begin
          p_nxt = P_IDLE;
          if (rx_byte != (HEADER ^ op)) begin
            ce_n = 1'b1;
          end else begin
            unique case (1'b1)
              (op == 8'h01): sw_n = 1'b1;
              (op == 8'h02): sr_n = 1'b1;
              (op == 8'h03): sp_n = 1'b1;
              (op == 8'h04): so_n = 1'b1;
              default:       ce_n = 1'b1;
            endcase
          end
          if (!ce_n) lop_nxt = op;
        end
      end
      default: p_nxt = P_IDLE;
    endcase
    if (p_state != P_IDLE && !rx_dv &&
        (ferr_nxt || tcnt == T_FIRE)) begin
      p_nxt = P_IDLE;
      ce_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= P_IDLE;
      op          <= '0;
      tcnt        <= '0;
      last_opcode <= '0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      stop_cmd    <= 1'b0;
      soft_rst    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      p_state     <= p_nxt;
      op          <= op_nxt;
      tcnt        <= t_nxt;
      last_opcode <= lop_nxt;
      start_write <= sw_n;
      start_read  <= sr_n;
      stop_cmd    <= sp_n;
      soft_rst    <= so_n;
      cmd_err     <= ce_n;
    end
  end

  assign busy = (rx_state != RX_IDLE) | (p_state != P_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed checks of the UART command receiver.
// Second instance at 16 clk/bit checks +-2% baud tolerance.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CPB = 64;
  localparam int TO  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic rx16 = 1'b1;

  always #5 clk = ~clk;

  logic       rx_dv, frame_err, busy;
  logic [7:0] rx_byte, last_opcode;
  logic       start_write, start_read;
  logic       stop_cmd, soft_rst, cmd_err;

  logic       rx_dv_16, frame_err_16, busy_16;
  logic [7:0] rx_byte_16, last_opcode_16;
  logic       start_write_16, start_read_16;
  logic       stop_cmd_16, soft_rst_16, cmd_err_16;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .HEADER(8'hA5)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_dv(rx_dv), .rx_byte(rx_byte),
    .frame_err(frame_err),
    .start_write(start_write), .start_read(start_read),
    .stop_cmd(stop_cmd), .soft_rst(soft_rst),
    .cmd_err(cmd_err), .last_opcode(last_opcode),
    .busy(busy)
  );

  uart_cmd_rx #(
    .CLKS_PER_BIT(16), .TIMEOUT_CLKS(TO), .HEADER(8'hA5)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .rx(rx16),
    .rx_dv(rx_dv_16), .rx_byte(rx_byte_16),
    .frame_err(frame_err_16),
    .start_write(start_write_16), .start_read(start_read_16),
    .stop_cmd(stop_cmd_16), .soft_rst(soft_rst_16),
    .cmd_err(cmd_err_16), .last_opcode(last_opcode_16),
    .busy(busy_16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_dv = 0, n_ferr = 0, n_cerr = 0;
  int n_sw = 0, n_sr = 0, n_sp = 0, n_so = 0;
  int n_multi = 0, n_ferr16 = 0, n_ev16 = 0;
  int dv_cyc = 0, sw_cyc = 0, sr_cyc = 0;
  int cerr_cyc = 0, ferr_cyc = 0;
  logic [7:0] byte_q[$];
  logic [7:0] q16[$];

  always @(negedge clk) begin
    if (rx_dv) begin
      n_dv++;
      dv_cyc = cyc;
      byte_q.push_back(rx_byte);
    end
    if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
    if (cmd_err) begin n_cerr++; cerr_cyc = cyc; end
    if (start_write) begin n_sw++; sw_cyc = cyc; end
    if (start_read) begin n_sr++; sr_cyc = cyc; end
    if (stop_cmd) n_sp++;
    if (soft_rst) n_so++;
    if ($countones({start_write, start_read, stop_cmd,
                    soft_rst, cmd_err}) > 1)
      n_multi++;
    if (rx_dv_16) q16.push_back(rx_byte_16);
    if (frame_err_16) n_ferr16++;
    if (start_write_16 | start_read_16 | stop_cmd_16 |
        soft_rst_16 | cmd_err_16)
      n_ev16++;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a,
                            input logic [7:0] b,
                            input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
    tick(4);
  endtask

  task automatic send16(input logic [7:0] b, input int bt);
    rx16 = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx16 = b[i];
      #(bt);
    end
    rx16 = 1'b1;
    #(bt);
    #(bt);
  endtask

  function automatic logic [23:0] outs();
    return {rx_dv, rx_byte, frame_err, start_write,
            start_read, stop_cmd, soft_rst, cmd_err,
            last_opcode, busy};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_tests++;
    if (outs() !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 000000", outs());
    end
    rst_n = 1'b1;
    tick(5);
    n_tests++;
    if (outs() !== 24'h0) begin
      n_fail++;
      $display("FAIL post_reset_outs: got %h want 000000",
               outs());
    end
  endtask

  task automatic test_write();
    int d0, q0, sw0, ce0;
    logic [23:0] got;
    d0 = n_dv; q0 = byte_q.size();
    sw0 = n_sw; ce0 = n_cerr;
    send_frame(8'hA5, 8'h01, 8'hA4);
    n_tests++;
    if (n_dv - d0 !== 3) begin
      n_fail++;
      $display("FAIL wr_dv_count: got %0d want 3", n_dv - d0);
    end
    got = 24'hx;
    if (byte_q.size() >= q0 + 3)
      got = {byte_q[q0], byte_q[q0+1], byte_q[q0+2]};
    n_tests++;
    if (got !== 24'hA501A4) begin
      n_fail++;
      $display("FAIL wr_bytes: got %h want a501a4", got);
    end
    n_tests++;
    if (n_sw - sw0 !== 1) begin
      n_fail++;
      $display("FAIL wr_pulse_cnt: got %0d want 1", n_sw - sw0);
    end
    n_tests++;
    if (sw_cyc !== dv_cyc + 1) begin
      n_fail++;
      $display("FAIL wr_latency: got %0d want 1",
               sw_cyc - dv_cyc);
    end
    n_tests++;
    if (last_opcode !== 8'h01) begin
      n_fail++;
      $display("FAIL wr_lastop: got %h want 01", last_opcode);
    end
    n_tests++;
    if (n_cerr - ce0 !== 0) begin
      n_fail++;
      $display("FAIL wr_cmd_err: got %0d want 0", n_cerr - ce0);
    end
  endtask

  task automatic test_checksum();
    int ce0, sr0;
    ce0 = n_cerr; sr0 = n_sr;
    send_frame(8'hA5, 8'h02, 8'h00);
    n_tests++;
    if (n_cerr - ce0 !== 1) begin
      n_fail++;
      $display("FAIL chk_err_cnt: got %0d want 1", n_cerr - ce0);
    end
    n_tests++;
    if (cerr_cyc !== dv_cyc + 1) begin
      n_fail++;
      $display("FAIL chk_err_lat: got %0d want 1",
               cerr_cyc - dv_cyc);
    end
    n_tests++;
    if (n_sr - sr0 !== 0 || last_opcode !== 8'h01) begin
      n_fail++;
      $display("FAIL chk_no_cmd: got rd=%0d op=%h want 0 01",
               n_sr - sr0, last_opcode);
    end
    send_frame(8'hA5, 8'h02, 8'hA7);
    n_tests++;
    if (n_sr - sr0 !== 1 || sr_cyc !== dv_cyc + 1) begin
      n_fail++;
      $display("FAIL rd_pulse: got cnt=%0d lat=%0d want 1 1",
               n_sr - sr0, sr_cyc - dv_cyc);
    end
    n_tests++;
    if (last_opcode !== 8'h02 || n_cerr - ce0 !== 1) begin
      n_fail++;
      $display("FAIL rd_lastop: got op=%h err=%0d want 02 1",
               last_opcode, n_cerr - ce0);
    end
  endtask

  task automatic test_bad_opcode();
    int ce0, c0, d0, f0;
    ce0 = n_cerr;
    c0 = n_sw + n_sr + n_sp + n_so;
    send_frame(8'hA5, 8'h07, 8'hA2);
    n_tests++;
    if (n_cerr - ce0 !== 1) begin
      n_fail++;
      $display("FAIL badop_err: got %0d want 1", n_cerr - ce0);
    end
    n_tests++;
    if (n_sw + n_sr + n_sp + n_so - c0 !== 0 ||
        last_opcode !== 8'h02) begin
      n_fail++;
      $display("FAIL badop_cmd: got %0d op=%h want 0 02",
               n_sw + n_sr + n_sp + n_so - c0, last_opcode);
    end
    d0 = n_dv; f0 = n_ferr;
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(100);
    n_tests++;
    if (n_dv - d0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_dv: got %0d want 0", n_dv - d0);
    end
    n_tests++;
    if (n_ferr - f0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_frame_err();
    int f0, ce0, so0;
    f0 = n_ferr; ce0 = n_cerr; so0 = n_so;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);
    tick(4);
    n_tests++;
    if (n_ferr - f0 !== 1 || n_cerr - ce0 !== 1) begin
      n_fail++;
      $display("FAIL ferr_cnt: got f=%0d e=%0d want 1 1",
               n_ferr - f0, n_cerr - ce0);
    end
    n_tests++;
    if (ferr_cyc !== cerr_cyc) begin
      n_fail++;
      $display("FAIL ferr_same_cyc: got %0d want %0d",
               cerr_cyc, ferr_cyc);
    end
    n_tests++;
    if (rx_byte !== 8'hA5) begin
      n_fail++;
      $display("FAIL ferr_hold: got %h want a5", rx_byte);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_busy: got %b want 0", busy);
    end
    send_frame(8'hA5, 8'h04, 8'hA1);
    n_tests++;
    if (n_so - so0 !== 1 || last_opcode !== 8'h04) begin
      n_fail++;
      $display("FAIL softrst: got cnt=%0d op=%h want 1 04",
               n_so - so0, last_opcode);
    end
  endtask

  task automatic test_timeout();
    int ce0, sp0, d;
    int waited;
    ce0 = n_cerr; sp0 = n_sp;
    send_byte(8'hA5, 1'b1);
    d = dv_cyc;
    waited = 0;
    while (n_cerr == ce0 && waited < 1200) begin
      tick(1);
      waited++;
    end
    n_tests++;
    if (n_cerr - ce0 !== 1) begin
      n_fail++;
      $display("FAIL tmo_err: got %0d want 1", n_cerr - ce0);
    end
    n_tests++;
    if (cerr_cyc - d !== TO) begin
      n_fail++;
      $display("FAIL tmo_delay: got %0d want %0d",
               cerr_cyc - d, TO);
    end
    tick(2);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_busy: got %b want 0", busy);
    end
    send_frame(8'hA5, 8'h03, 8'hA6);
    n_tests++;
    if (n_sp - sp0 !== 1 || last_opcode !== 8'h03) begin
      n_fail++;
      $display("FAIL stop_cmd: got cnt=%0d op=%h want 1 03",
               n_sp - sp0, last_opcode);
    end
  endtask

  task automatic test_mid_reset();
    int sw0;
    logic [7:0] b;
    b = 8'h01;
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[4];
    tick(10);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (outs() !== 24'h0) begin
      n_fail++;
      $display("FAIL midrst_outs: got %h want 000000", outs());
    end
    rx = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(5);
    sw0 = n_sw;
    send_frame(8'hA5, 8'h01, 8'hA4);
    n_tests++;
    if (n_sw - sw0 !== 1 || last_opcode !== 8'h01) begin
      n_fail++;
      $display("FAIL midrst_wr: got cnt=%0d op=%h want 1 01",
               n_sw - sw0, last_opcode);
    end
  endtask

  task automatic test_baud_sweep();
    logic [7:0] pat[5];
    logic [7:0] exp_b;
    logic [7:0] got;
    pat = '{8'h00, 8'hFF, 8'h55, 8'hC3, 8'h81};
    for (int i = 0; i < 5; i++) send16(pat[i], 163);
    for (int i = 0; i < 5; i++) send16(pat[i], 157);
    tick(5);
    n_tests++;
    if (q16.size() !== 10) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d want 10", q16.size());
    end
    for (int i = 0; i < 10; i++) begin
      exp_b = pat[i % 5];
      got = (i < q16.size()) ? q16[i] : 8'hxx;
      n_tests++;
      if (got !== exp_b) begin
        n_fail++;
        $display("FAIL sweep_byte%0d: got %h want %h",
                 i, got, exp_b);
      end
    end
    n_tests++;
    if (n_ferr16 !== 0 || n_ev16 !== 0 ||
        busy_16 !== 1'b0 || last_opcode_16 !== 8'h00) begin
      n_fail++;
      $display("FAIL sweep_misc: got f=%0d e=%0d b=%b op=%h want 0 0 0 00",
               n_ferr16, n_ev16, busy_16, last_opcode_16);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_write();
    test_checksum();
    test_bad_opcode();
    test_frame_err();
    test_timeout();
    test_mid_reset();
    test_baud_sweep();
    n_tests++;
    if (n_multi !== 0) begin
      n_fail++;
      $display("FAIL onehot_pulses: got %0d want 0", n_multi);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
